sap_muldiv_unit: RTL and testbench

//   Iterative unsigned multiply/divide unit on the SAP-1 datapath, beside the adder.

---
 rtl/sap_muldiv_unit.sv | 84 ++++++++
 tb/tb_sap_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_muldiv_unit.sv
// sap_muldiv_unit: iterative unsigned shift-add multiplier / restoring divider for the SAP-1 datapath.
module sap_muldiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             out_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] bus_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic             op_r;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH:0] acc, acc_nx, mul_nx, div_nx;
    logic [WIDTH:0]   sum, rem_sh;
    logic             accept, dz, last;

    assign accept = start && state != RUN;
    assign dz     = op && b == '0;
    assign last   = count == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state == RUN) ? (last ? DONE : RUN) : accept ? (dz ? DONE : RUN) : IDLE;
    end

    // acc holds {carry/partial remainder, shifting multiplier/quotient}; opnd is the addend or divisor
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nx = {1'b0, sum, acc[WIDTH-1:1]};
    assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
    assign div_nx = (rem_sh >= {1'b0, opnd}) ? {rem_sh - {1'b0, opnd}, acc[WIDTH-2:0], 1'b1}
                                             : {rem_sh, acc[WIDTH-2:0], 1'b0};
    assign acc_nx = op_r ? div_nx : mul_nx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count       <= '0;
            op_r        <= 1'b0;
            opnd        <= '0;
            acc         <= '0;
            result      <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count       <= '0;
            op_r        <= op;
            opnd        <= op ? b : a;
            acc         <= {{(WIDTH + 1){1'b0}}, op ? a : b};
            result      <= dz ? '1 : '0;
            remainder   <= dz ? a : '0;
            overflow    <= 1'b0;
            div_by_zero <= dz;
        end else if (state == RUN) begin
            acc   <= acc_nx;
            count <= count + 1'b1;
            if (last) begin
                result    <= acc_nx[WIDTH-1:0];
                remainder <= op_r ? acc_nx[2*WIDTH-1:WIDTH] : '0;
                overflow  <= !op_r && |acc_nx[2*WIDTH-1:WIDTH];
            end
        end

    assign busy    = state == RUN;
    assign done    = state == DONE;
    assign bus_out = out_en ? result : '0;
endmodule

// File: tb/tb_sap_muldiv_unit.sv
// tb_sap_muldiv_unit: randomized self-checking bench for sap_muldiv_unit against an arithmetic model.
module tb_sap_muldiv_unit;
    logic       clk = 0, rst_n = 0, start = 0, op = 0, out_en = 0;
    logic [7:0] a = 0, b = 0;
    logic       busy, done, overflow, div_by_zero;
    logic [7:0] result, remainder, bus_out;
    int         checks = 0, failures = 0;

    sap_muldiv_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .out_en(out_en),
        .busy(busy), .done(done), .result(result), .remainder(remainder),
        .overflow(overflow), .div_by_zero(div_by_zero), .bus_out(bus_out)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic o, input logic [7:0] x, y,
                                  output logic [7:0] r, m, output logic v, z);
        int p;
        p = int'(x) * int'(y);
        if (!o) begin
            r = p[7:0]; m = 0; v = (p >> 8) != 0; z = 0;
        end else if (y == 0) begin
            r = 8'hFF; m = x; v = 0; z = 1;
        end else begin
            r = x / y; m = x % y; v = 0; z = 0;
        end
    endfunction

    // Drives one start, scrambles operands afterwards, and waits (bounded) for done.
    task automatic launch(input logic o, input logic [7:0] x, y, output int cyc, output int busy_n);
        @(negedge clk);
        op = o; a = x; b = y; start = 1;
        @(posedge clk);
        #1 start = 0;
        a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
        cyc = 0; busy_n = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 0; out_en = 1; a = 8'hA5; b = 8'h3C; start = 1;
        #12;
        checks++;
        if ({busy, done, result, remainder, overflow, div_by_zero, bus_out} !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b r=%h rem=%h ovf=%b dz=%b bus=%h, all must be 0",
                     busy, done, result, remainder, overflow, div_by_zero, bus_out);
        end
        start = 0;
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_multiply;
        logic [7:0] xs[5] = '{13, 200, 0, 77, 255};
        logic [7:0] ys[5] = '{11, 3, 99, 0, 255};
        logic [7:0] x, y, er, em;
        logic ev, ez;
        int cyc, bn;
        for (int i = 0; i < 17; i++) begin
            x = i < 5 ? xs[i] : 8'($urandom);
            y = i < 5 ? ys[i] : 8'($urandom);
            model(0, x, y, er, em, ev, ez);
            launch(0, x, y, cyc, bn);
            checks++;
            if ({result, remainder, overflow, div_by_zero} !== {er, em, ev, ez}) begin
                failures++;
                $display("FAIL mul %0d*%0d: got r=%0d rem=%0d ovf=%b dz=%b want r=%0d rem=%0d ovf=%b dz=%b",
                         x, y, result, remainder, overflow, div_by_zero, er, em, ev, ez);
            end
            checks++;
            if (cyc !== 8 || bn !== 8) begin
                failures++;
                $display("FAIL mul_latency %0d*%0d: got done_at=%0d busy_cycles=%0d want 8/8", x, y, cyc, bn);
            end
            out_en = 1'($urandom);
            #1 checks++;
            if (bus_out !== (out_en ? er : 8'h00)) begin
                failures++;
                $display("FAIL mul_bus out_en=%b: got %h want %h", out_en, bus_out, out_en ? er : 8'h00);
            end
        end
    endtask

    task automatic test_divide;
        logic [7:0] xs[6] = '{100, 5, 200, 37, 0, 255};
        logic [7:0] ys[6] = '{7, 9, 1, 200, 5, 1};
        logic [7:0] x, y, er, em;
        logic ev, ez;
        int cyc, bn;
        for (int i = 0; i < 18; i++) begin
            x = i < 6 ? xs[i] : 8'($urandom);
            y = i < 6 ? ys[i] : 8'($urandom_range(1, 255));
            model(1, x, y, er, em, ev, ez);
            launch(1, x, y, cyc, bn);
            checks++;
            if ({result, remainder, overflow, div_by_zero} !== {er, em, ev, ez}) begin
                failures++;
                $display("FAIL div %0d/%0d: got q=%0d rem=%0d ovf=%b dz=%b want q=%0d rem=%0d ovf=%b dz=%b",
                         x, y, result, remainder, overflow, div_by_zero, er, em, ev, ez);
            end
            checks++;
            if (cyc !== 8 || bn !== 8) begin
                failures++;
                $display("FAIL div_latency %0d/%0d: got done_at=%0d busy_cycles=%0d want 8/8", x, y, cyc, bn);
            end
            out_en = 1'($urandom);
            #1 checks++;
            if (bus_out !== (out_en ? er : 8'h00)) begin
                failures++;
                $display("FAIL div_bus out_en=%b: got %h want %h", out_en, bus_out, out_en ? er : 8'h00);
            end
        end
        repeat (3) @(posedge clk);
        #1 checks++;
        if ({result, remainder, done, busy} !== {er, em, 2'b00}) begin
            failures++;
            $display("FAIL div_hold: got q=%0d rem=%0d done=%b busy=%b want q=%0d rem=%0d idle",
                     result, remainder, done, busy, er, em);
        end
    endtask

    task automatic test_div_by_zero;
        int cyc, bn;
        launch(1, 5, 0, cyc, bn);
        checks++;
        if ({result, remainder, overflow, div_by_zero} !== {8'hFF, 8'd5, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL dbz: got q=%h rem=%0d ovf=%b dz=%b want q=ff rem=5 ovf=0 dz=1",
                     result, remainder, overflow, div_by_zero);
        end
        checks++;
        if (cyc !== 0 || bn !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL dbz_latency: got done_at=%0d busy_cycles=%0d busy=%b want 0/0/0", cyc, bn, busy);
        end
    endtask

    task automatic test_start_during_busy;
        int cyc, first, ndone;
        logic [7:0] r_at_done;
        @(negedge clk);
        op = 0; a = 6; b = 7; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 2; b = 2; start = 1;
        @(posedge clk);
        #1 start = 0;
        cyc = 3; first = -1; ndone = 0; r_at_done = 0;
        while (cyc < 20) begin
            if (done) begin
                ndone++;
                if (first < 0) begin first = cyc; r_at_done = result; end
            end
            @(posedge clk);
            #1 cyc++;
        end
        checks++;
        if (first !== 8 || ndone !== 1) begin
            failures++;
            $display("FAIL busy_start_timing: got first_done=%0d pulses=%0d want 8/1", first, ndone);
        end
        checks++;
        if (r_at_done !== 8'd42 || result !== 8'd42) begin
            failures++;
            $display("FAIL busy_start_result: got %0d (held %0d) want 42", r_at_done, result);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bn;
        launch(0, 9, 9, cyc, bn);
        checks++;
        if (done !== 1 || result !== 8'd81) begin
            failures++;
            $display("FAIL b2b_first: got done=%b r=%0d want 1/81", done, result);
        end
        launch(1, 81, 4, cyc, bn);
        checks++;
        if (cyc !== 8 || result !== 8'd20 || remainder !== 8'd1) begin
            failures++;
            $display("FAIL b2b_second: got done_at=%0d q=%0d rem=%0d want 8/20/1", cyc, result, remainder);
        end
        @(posedge clk);
        #1 checks++;
        if (done !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL b2b_pulse: got done=%b busy=%b one cycle later, want 0/0", done, busy);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bn, seen;
        @(negedge clk);
        op = 0; a = 15; b = 15; start = 1; out_en = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (4) @(posedge clk);
        #2 checks++;
        if (busy !== 1) begin
            failures++;
            $display("FAIL mid_busy: got busy=%b want 1 before reset", busy);
        end
        rst_n = 0;
        #1 checks++;
        if ({busy, done, result, remainder, overflow, div_by_zero, bus_out} !== '0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b done=%b r=%h rem=%h ovf=%b dz=%b bus=%h, all must be 0",
                     busy, done, result, remainder, overflow, div_by_zero, bus_out);
        end
        @(negedge clk) rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_no_done: got %0d done pulses after reset want 0", seen);
        end
        launch(0, 15, 15, cyc, bn);
        checks++;
        if (cyc !== 8 || result !== 8'd225 || overflow !== 0) begin
            failures++;
            $display("FAIL mid_recover: got done_at=%0d r=%0d ovf=%b want 8/225/0", cyc, result, overflow);
        end
        out_en = 0;
        #1 checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL bus_idle: got %h with out_en=0 want 00", bus_out);
        end
    endtask

    initial begin
        test_reset;
        test_multiply;
        test_divide;
        test_div_by_zero;
        test_start_during_busy;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
